int_regfile_sb: RTL and testbench
=================================

Name: int_regfile_sb

Overview:
- Parametrised successor to the single-write integer register file.
- Two combinational read ports.
- Write port A serves fixed-latency (ALU/load) results and is always accepted.
- Write port B serves long-latency (APU/FPU) results and has a valid/ready handshake.
- An issue-time scoreboard tracks outstanding long-latency destinations and exports per-operand busy flags for the issue stage's stall logic.

Parameters:
- XLEN, 32, data width of every register.
- NREGS, 32, register count; address width AW = $clog2(NREGS); register 0 hardwired to zero.
- MAX_PENDING, 8, maximum simultaneously reserved destinations; range 1..NREGS-1.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- rs1_busy  out  1  rs1 has a pending long-latency write; issue stage must stall.
- rs2_busy  out  1  rs2 has a pending long-latency write; issue stage must stall.
- wa_en  in  1  port A write enable.
- wa_addr  in  AW  port A destination.
- wa_data  in  XLEN  port A data.
- iss_valid  in  1  reserve destination iss_rd for a long-latency op.
- iss_rd  in  AW  destination to reserve.
- iss_ready  out  1  reservation accepted this cycle.
- wb_valid  in  1  port B writeback valid.
- wb_rd  in  AW  port B destination.
- wb_data  in  XLEN  port B data.
- wb_ready  out  1  port B writeback accepted this cycle.
- pend_count  out  $clog2(MAX_PENDING+1)  number of reserved registers.
- wb_err  out  1  sticky flag: writeback arrived for a non-reserved register.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, busy bits, pend_count and wb_err go to 0.
  - In-flight reservations are discarded; a wb arriving after reset sets wb_err.
- Register 0:
  - reads return 0; writes on either port are ignored.
  - iss_rd=0: iss_ready=1, no bit set, pend_count unchanged.
  - wb_rd=0: wb_ready=1, data dropped, busy/err untouched.
- Reads:
  - rsN_data = reg[rsN_addr] combinationally.
  - A rising-edge write becomes visible to reads in the following cycle (write-then-read latency of 1 without bypass).
- Port A:
  - writes reg[wa_addr] on the rising edge when wa_en=1.
  - No scoreboard effect.
- Port B handshake:
  - wb fire = wb_valid & wb_ready.
  - wb_ready = !(wa_en & wa_addr==wb_rd & wb_rd!=0): port A wins an address collision.
  - On a collision, port B holds wb_rd/wb_data stable and retries next cycle.
  - On fire with busy[wb_rd]=1: write data, clear busy[wb_rd], decrement pend_count.
  - On fire with busy[wb_rd]=0: data dropped, wb_err set and held until reset.
- Issue:
  - iss fire = iss_valid & iss_ready.
  - iss_ready=0 if busy[iss_rd] is set and not being cleared by a same-cycle wb fire (WAW hazard).
  - iss_ready=0 if pend_count==MAX_PENDING and no wb fire this cycle (full).
  - Otherwise iss_ready=1.
  - On fire: busy[iss_rd] set, pend_count incremented.
- Simultaneous iss fire and wb fire:
  - Same register: busy stays 1, pend_count unchanged.
  - Different registers: set one bit, clear the other, pend_count unchanged.
- Busy flags:
  - rsN_busy = busy[rsN_addr] & rsN_addr!=0, then modified by the bypass option (see Optional Feature).
  - Busy flags are not raised by port A writes.
- Invariant: pend_count always equals popcount(busy).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - read data forwards a same-cycle write to the read address: port A data if wa_en & wa_addr match, else wb_data on a wb fire match.
  - rsN_busy is masked to 0 when a wb fire targets rsN_addr in that cycle.
- Undefined:
  - read data is always the stored value.
  - rsN_busy is also asserted when a same-cycle wb fire targets rsN_addr, so the consumer waits one cycle for the committed value.

Test Plan:
- Reset: drive reset=0 mid-run with 3 reservations pending -> all reads 0, pend_count=0, busy flags 0, wb_err=0; a later wb to x5 sets wb_err=1.
- Port A: write x3=0xDEADBEEF; read rs1=3 next cycle -> 0xDEADBEEF. Write x0=0x1234 -> rs1_addr=0 reads 0.
- Reservation and writeback: issue x7 -> rs2_addr=7 gives rs2_busy=1, pend_count=1. wb x7=0x55AA55AA -> busy clears, pend_count=0, read returns 0x55AA55AA; re-issue of x7 is refused (iss_ready=0) while x7 is busy.
- Collision: wa_en to x9 and wb fire to x9 in the same cycle -> wb_ready=0, reg[x9]=port A data. Next cycle wb retires, reg[x9]=wb_data, busy[x9]=0.
- Full: MAX_PENDING=8 reservations -> iss_ready=0 for a 9th; a same-cycle wb fire lets the 9th in with pend_count held at 8.
- Bypass: wb fire to x4=0x11112222 with rs1_addr=4 in the same cycle -> with REGFILE_BYPASS_EN, rs1_data=0x11112222 and rs1_busy=0; without it, old value and rs1_busy=1.

Source files
------------

// File: rtl/int_regfile_sb.sv
// int_regfile_sb: integer register file with two combinational read ports,
// an always-accepted fixed-latency write port (A), a handshaked long-latency
// writeback port (B), and an issue-time scoreboard of pending destinations.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - reads forward same-cycle writes; rsN_busy drops when a
//               writeback to rsN_addr fires this cycle.
//   undefined - reads return stored data; rsN_busy stays high during the
//               writeback cycle so the consumer picks up the committed value.
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   rs1_addr/rs2_addr     read addresses
//   rs1_data/rs2_data     read data (combinational)
//   rs1_busy/rs2_busy     operand has a pending long-latency write
//   wa_en/wa_addr/wa_data port A write (always accepted)
//   iss_valid/iss_rd      reserve a destination; iss_ready = accepted
//   wb_valid/wb_rd/wb_data port B writeback; wb_ready = accepted
//   pend_count            number of reserved registers
//   wb_err                sticky: writeback to a non-reserved register
module int_regfile_sb #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int MAX_PENDING = 8,
  localparam int AW         = $clog2(NREGS),
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  output logic [PW-1:0]   pend_count,
  output logic            wb_err
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  logic wb_nz, wb_fire, wb_retire, wb_stray;
  logic iss_waw, iss_full, iss_set;

  // Port A wins an address collision; port B retries next cycle.
  assign wb_ready  = !(wa_en && (wa_addr == wb_rd) && (wb_rd != '0));
  assign wb_fire   = wb_valid && wb_ready;
  assign wb_nz     = (wb_rd != '0);
  assign wb_retire = wb_fire && wb_nz && busy[wb_rd];
  assign wb_stray  = wb_fire && wb_nz && !busy[wb_rd];

  // Only a retiring writeback frees a slot or clears a WAW hazard; a stray
  // writeback leaves the scoreboard untouched, so counting it would let
  // pend_count overrun MAX_PENDING.
  assign iss_waw   = busy[iss_rd] && !(wb_retire && (wb_rd == iss_rd));
  assign iss_full  = (pend_count == PW'(MAX_PENDING)) && !wb_retire;
  assign iss_ready = (iss_rd == '0) || (!iss_waw && !iss_full);
  assign iss_set   = iss_valid && iss_ready && (iss_rd != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy       <= '0;
      pend_count <= '0;
      wb_err     <= 1'b0;
    end else begin
      if (wa_en && (wa_addr != '0)) regs[wa_addr] <= wa_data;
      if (wb_retire) begin
        regs[wb_rd] <= wb_data;
        busy[wb_rd] <= 1'b0;
      end
      // Set after clear so a same-register retire+reserve leaves busy high.
      if (iss_set) busy[iss_rd] <= 1'b1;
      pend_count <= pend_count + PW'(iss_set) - PW'(wb_retire);
      if (wb_stray) wb_err <= 1'b1;
    end
  end

  logic [AW-1:0]   rd_addr [2];
  logic [XLEN-1:0] rd_data [2];
  logic            rd_busy [2];

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = (rd_addr[p] == '0) ? '0 : regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]] && (rd_addr[p] != '0);
`ifdef REGFILE_BYPASS_EN
      if (rd_addr[p] != '0) begin
        if (wa_en && (wa_addr == rd_addr[p])) rd_data[p] = wa_data;
        else if (wb_retire && (wb_rd == rd_addr[p])) rd_data[p] = wb_data;
      end
      if (wb_fire && (wb_rd == rd_addr[p])) rd_busy[p] = 1'b0;
`else
      if (wb_fire && wb_nz && (wb_rd == rd_addr[p])) rd_busy[p] = 1'b1;
`endif
    end
  end

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];
  assign rs1_busy = rd_busy[0];
  assign rs2_busy = rd_busy[1];

endmodule

// File: tb/tb_int_regfile_sb.sv
module tb_int_regfile_sb;
  localparam int NREGS = 32;
  localparam int MAXP  = 8;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_D = 32'h1111_2222;
  localparam bit          BYP_B = 1'b0;
`else
  localparam logic [31:0] BYP_D = 32'h0;
  localparam bit          BYP_B = 1'b1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        wa_en = 1'b0;
  logic [4:0]  wa_addr = '0;
  logic [31:0] wa_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready;
  logic [3:0]  pend_count;
  logic        wb_err;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  int_regfile_sb dut (
    .clock(clock), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .pend_count(pend_count), .wb_err(wb_err)
  );

  // Reference model: architectural register contents, reservation set, error flag.
  logic [31:0] m_reg [NREGS];
  bit          m_busy [NREGS];
  bit          m_err;

  function automatic int m_pend();
    int n = 0;
    for (int i = 0; i < NREGS; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic bit e_wb_ready();
    return !(wa_en && wa_addr == wb_rd && wb_rd != 0);
  endfunction

  function automatic bit e_wb_fire();
    return wb_valid && e_wb_ready();
  endfunction

  function automatic bit e_frees();
    return e_wb_fire() && wb_rd != 0 && m_busy[wb_rd];
  endfunction

  function automatic bit e_iss_ready();
    if (iss_rd == 0) return 1'b1;
    if (m_busy[iss_rd] && !(e_frees() && wb_rd == iss_rd)) return 1'b0;
    if (m_pend() == MAXP && !e_frees()) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] e_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wa_en && wa_addr == a) return wa_data;
    if (e_frees() && wb_rd == a) return wb_data;
`endif
    return m_reg[a];
  endfunction

  function automatic bit e_busy(input logic [4:0] a);
    bit tgt;
    tgt = e_wb_fire() && wb_rd == a;
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    return m_busy[a] && !tgt;
`else
    return m_busy[a] || tgt;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic compare();
    chk("rs1_data",   rs1_data,          e_data(rs1_addr));
    chk("rs2_data",   rs2_data,          e_data(rs2_addr));
    chk("rs1_busy",   32'(rs1_busy),     32'(e_busy(rs1_addr)));
    chk("rs2_busy",   32'(rs2_busy),     32'(e_busy(rs2_addr)));
    chk("iss_ready",  32'(iss_ready),    32'(e_iss_ready()));
    chk("wb_ready",   32'(wb_ready),     32'(e_wb_ready()));
    chk("pend_count", 32'(pend_count),   32'(m_pend()));
    chk("wb_err",     32'(wb_err),       32'(m_err));
  endtask

  // Commit the current inputs across one rising edge, then return at the negedge.
  task automatic advance();
    bit wa_w, wbf, isf;
    logic [4:0] wa_a, wb_a, is_a;
    logic [31:0] wa_d, wb_d;
    wa_w = wa_en && wa_addr != 0;
    wbf  = e_wb_fire() && wb_rd != 0;
    isf  = iss_valid && e_iss_ready() && iss_rd != 0;
    wa_a = wa_addr; wa_d = wa_data; wb_a = wb_rd; wb_d = wb_data; is_a = iss_rd;
    @(posedge clock);
    if (wbf) begin
      if (m_busy[wb_a]) begin
        m_reg[wb_a]  = wb_d;
        m_busy[wb_a] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (wa_w) m_reg[wa_a] = wa_d;
    if (isf) m_busy[is_a] = 1'b1;
    @(negedge clock);
  endtask

  task automatic drv(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit iv, input logic [4:0] ir,
                     input bit bv, input logic [4:0] br, input logic [31:0] bd,
                     input logic [4:0] r1, input logic [4:0] r2);
    wa_en = we; wa_addr = wa; wa_data = wd;
    iss_valid = iv; iss_rd = ir;
    wb_valid = bv; wb_rd = br; wb_data = bd;
    rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic cyc();
    #1;
    compare();
    advance();
  endtask

  typedef struct {
    bit          wa_en;  logic [4:0] wa_addr; logic [31:0] wa_data;
    bit          iss_v;  logic [4:0] iss_rd;
    bit          wb_v;   logic [4:0] wb_rd;   logic [31:0] wb_data;
    logic [4:0]  rs1;    logic [4:0] rs2;
    logic [31:0] e_d;    bit e_b; bit e_ir; bit e_wr; logic [3:0] e_p;
  } vec_t;

  vec_t vt [15];

  initial begin
    // Directed vectors; expected columns are the pre-edge outputs of that cycle.
    vt[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0,            0, 0, 32'h0,        0, 1, 1, 0};
    vt[1]  = '{0, 0, 0,            0, 0, 0, 0, 0,            3, 0, 32'hDEADBEEF, 0, 1, 1, 0};
    vt[2]  = '{1, 0, 32'h1234,     0, 0, 0, 0, 0,            3, 0, 32'hDEADBEEF, 0, 1, 1, 0};
    vt[3]  = '{0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 32'h0,        0, 1, 1, 0};
    vt[4]  = '{0, 0, 0,            1, 7, 0, 0, 0,            7, 0, 32'h0,        0, 1, 1, 0};
    vt[5]  = '{0, 0, 0,            1, 7, 0, 0, 0,            7, 0, 32'h0,        1, 0, 1, 1};
    vt[6]  = '{0, 0, 0,            0, 0, 1, 7, 32'h55AA55AA, 3, 7, 32'hDEADBEEF, 0, 1, 1, 1};
    vt[7]  = '{0, 0, 0,            0, 0, 0, 0, 0,            7, 0, 32'h55AA55AA, 0, 1, 1, 0};
    vt[8]  = '{0, 0, 0,            1, 9, 0, 0, 0,            3, 0, 32'hDEADBEEF, 0, 1, 1, 0};
    vt[9]  = '{1, 9, 32'hAAAA0000, 0, 0, 1, 9, 32'hBBBB1111, 3, 9, 32'hDEADBEEF, 0, 1, 0, 1};
    vt[10] = '{0, 0, 0,            0, 0, 1, 9, 32'hBBBB1111, 3, 9, 32'hDEADBEEF, 0, 1, 1, 1};
    vt[11] = '{0, 0, 0,            0, 0, 0, 0, 0,            9, 0, 32'hBBBB1111, 0, 1, 1, 0};
    vt[12] = '{0, 0, 0,            1, 4, 0, 0, 0,            3, 0, 32'hDEADBEEF, 0, 1, 1, 0};
    vt[13] = '{0, 0, 0,            0, 0, 1, 4, 32'h11112222, 4, 0, BYP_D,        BYP_B, 1, 1, 1};
    vt[14] = '{0, 0, 0,            0, 0, 0, 0, 0,            4, 0, 32'h11112222, 0, 1, 1, 0};

    model_clear();
    reset = 1'b0;
    @(negedge clock);
    #1;
    compare();
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drv(vt[i].wa_en, vt[i].wa_addr, vt[i].wa_data, vt[i].iss_v, vt[i].iss_rd,
          vt[i].wb_v, vt[i].wb_rd, vt[i].wb_data, vt[i].rs1, vt[i].rs2);
      #1;
      compare();
      chk($sformatf("tv%0d_rs1_data", i),  rs1_data,         vt[i].e_d);
      chk($sformatf("tv%0d_rs1_busy", i),  32'(rs1_busy),    32'(vt[i].e_b));
      chk($sformatf("tv%0d_iss_ready", i), 32'(iss_ready),   32'(vt[i].e_ir));
      chk($sformatf("tv%0d_wb_ready", i),  32'(wb_ready),    32'(vt[i].e_wr));
      chk($sformatf("tv%0d_pend", i),      32'(pend_count),  32'(vt[i].e_p));
      advance();
    end

    // Full scoreboard: eight reservations, a ninth is refused until a retire frees a slot.
    for (int k = 10; k < 18; k++) begin
      drv(0, 0, 0, 1, 5'(k), 0, 0, 0, 5'(k), 0);
      #1;
      compare();
      chk("full_fill_ready", 32'(iss_ready), 32'd1);
      advance();
    end
    drv(0, 0, 0, 1, 18, 0, 0, 0, 18, 0);
    #1;
    compare();
    chk("full_refuse", 32'(iss_ready), 32'd0);
    chk("full_pend8", 32'(pend_count), 32'd8);
    advance();
    drv(0, 0, 0, 1, 18, 1, 10, 32'hC0FFEE10, 18, 10);
    #1;
    compare();
    chk("full_swap_ready", 32'(iss_ready), 32'd1);
    advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 18, 10);
    #1;
    compare();
    chk("full_swap_pend", 32'(pend_count), 32'd8);
    chk("full_swap_new_busy", 32'(rs1_busy), 32'd1);
    chk("full_swap_old_data", rs2_data, 32'hC0FFEE10);
    advance();
    for (int k = 11; k < 19; k++) begin
      drv(0, 0, 0, 0, 0, 1, 5'(k), 32'h0101_0101 * k, 5'(k), 0);
      cyc();
    end

    // Mid-run reset with three reservations outstanding.
    drv(0, 0, 0, 1, 5, 0, 0, 0, 0, 0);  cyc();
    drv(0, 0, 0, 1, 6, 0, 0, 0, 0, 0);  cyc();
    drv(0, 0, 0, 1, 20, 0, 0, 0, 3, 5); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 3, 5);
    #1;
    chk("pre_rst_pend", 32'(pend_count), 32'd3);
    reset = 1'b0;
    model_clear();
    #1;
    compare();
    chk("rst_rs1_data", rs1_data, 32'h0);
    chk("rst_pend", 32'(pend_count), 32'd0);
    chk("rst_rs2_busy", 32'(rs2_busy), 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 1, 5, 32'h5555_0005, 5, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    chk("rst_stray_err", 32'(wb_err), 32'd1);
    chk("rst_stray_data", rs1_data, 32'h0);
    advance();

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] bq [$];
      logic [4:0] br;
      bit bv;
      for (int i = 1; i < NREGS; i++) if (m_busy[i]) bq.push_back(5'(i));
      bv = 1'b0;
      br = 5'($urandom_range(0, 31));
      if (bq.size() > 0 && $urandom_range(0, 1) == 1) begin
        bv = 1'b1;
        br = bq[$urandom_range(0, bq.size() - 1)];
      end else if ($urandom_range(0, 15) == 0) begin
        bv = 1'b1;
      end
      wa_en     = ($urandom_range(0, 3) == 0);
      wa_addr   = ($urandom_range(0, 3) == 0) ? br : 5'($urandom_range(0, 31));
      wa_data   = $urandom;
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = ($urandom_range(0, 5) == 0) ? br : 5'($urandom_range(0, 31));
      wb_valid  = bv;
      wb_rd     = br;
      wb_data   = $urandom;
      rs1_addr  = ($urandom_range(0, 2) == 0) ? br : 5'($urandom_range(0, 31));
      rs2_addr  = ($urandom_range(0, 2) == 0) ? wa_addr : 5'($urandom_range(0, 31));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
